// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: state encoding and one-hot helper shared by the
// round-robin Wishbone arbiter.
package wb_rr_arbiter_pkg;

   localparam int NUM_MASTERS_MAX = 8;

   typedef enum logic [1:0] {IDLE, OWN, ABORT} arb_state_t;

   function automatic int oh2idx(input logic [NUM_MASTERS_MAX-1:0] i_oh);
      int r;
      r = 0;
      for (int i = 0; i < NUM_MASTERS_MAX; i++) if (i_oh[i]) r = i;
      return r;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the winner is the first
// requester at or after the pointer, wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic          o_valid
);

   always_comb begin
      o_grant = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(i_ptr) + k) % N;
         if (o_grant == '0 && i_req[j]) o_grant[j] = 1'b1;
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter sharing one slave among
// NUM_MASTERS masters; a watchdog ends stalled cycles with err.
module wb_rr_arbiter
   import wb_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
   output logic [DW-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic                        s_we_o,
   output logic [AW-1:0]               s_adr_o,
   output logic [DW-1:0]               s_dat_o,
   output logic [DW/8-1:0]             s_sel_o,
   input  logic [DW-1:0]               s_dat_i,
   input  logic                        s_ack_i,
   input  logic                        s_err_i,
   output logic [NUM_MASTERS-1:0]      grant_o
);

   localparam int N  = NUM_MASTERS;
   localparam int SW = DW / 8;
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t    r_state;
   logic [N-1:0]  r_grant;
   logic [PW-1:0] r_ptr;
   logic [CW-1:0] r_wdog;
   logic [N-1:0]  w_win;
   logic          w_valid;
   logic          w_own, w_cyc, w_stb, w_we, w_stall, w_fire;
   logic [AW-1:0] w_adr;
   logic [DW-1:0] w_dat;
   logic [SW-1:0] w_sel;
   logic [PW-1:0] w_next;

   rr_pick #(.N(N)) u_pick (
      .i_req  (m_cyc_i),
      .i_ptr  (r_ptr),
      .o_grant(w_win),
      .o_valid(w_valid)
   );

   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (r_grant[i]) begin
            w_cyc = m_cyc_i[i];
            w_stb = m_stb_i[i];
            w_we  = m_we_i[i];
            w_adr = m_adr_i[i*AW +: AW];
            w_dat = m_dat_i[i*DW +: DW];
            w_sel = m_sel_i[i*SW +: SW];
         end
      end
   end

   // Slave side is driven only while owning; ABORT and IDLE present an idle bus.
   assign w_own   = r_state == OWN;
   assign s_cyc_o = w_own & w_cyc;
   assign s_stb_o = w_own & w_stb;
   assign s_we_o  = w_own & w_we;
   assign s_adr_o = w_own ? w_adr : '0;
   assign s_dat_o = w_own ? w_dat : '0;
   assign s_sel_o = w_own ? w_sel : '0;

   assign w_stall = s_stb_o & ~s_ack_i & ~s_err_i;
   assign w_fire  = w_stall & (r_wdog == CW'(TIMEOUT));
   assign m_ack_o = (w_own & s_ack_i & ~s_err_i) ? r_grant : '0;
   assign m_err_o = (w_own & (s_err_i | w_fire)) ? r_grant : '0;
   assign m_dat_o = s_dat_i;
   assign grant_o = r_grant;
   assign w_next  = PW'((oh2idx(NUM_MASTERS_MAX'(r_grant)) + 1) % N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_wdog  <= '0;
      end else begin
         r_wdog <= (w_stall && !w_fire) ? r_wdog + 1'b1 : '0;
         case (r_state)
            IDLE: if (w_valid) begin
               r_grant <= w_win;
               r_state <= OWN;
            end
            OWN, ABORT: if (!w_cyc) begin
               r_state <= IDLE;
               r_grant <= '0;
               r_ptr   <= w_next;
            end else if (w_fire) r_state <= ABORT;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scoreboard bench for the round-robin Wishbone arbiter with
// a cycle-stepped master/slave model.
module tb_wb_rr_arbiter;

   localparam int NM = 4, AW = 32, DW = 32, SW = DW / 8, TO = 16;
   localparam logic [31:0] K = 32'hA5A5_5A5A;

   logic                clk = 1'b0, rst_n = 1'b0;
   logic [NM-1:0]       m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
   logic [NM*AW-1:0]    m_adr_i = '0;
   logic [NM*DW-1:0]    m_dat_i = '0;
   logic [NM*SW-1:0]    m_sel_i = '0;
   logic [DW-1:0]       m_dat_o, s_dat_o, s_dat_i = '0;
   logic [NM-1:0]       m_ack_o, m_err_o, grant_o;
   logic                s_cyc_o, s_stb_o, s_we_o, s_ack_i = 1'b0, s_err_i = 1'b0;
   logic [AW-1:0]       s_adr_o;
   logic [SW-1:0]       s_sel_o;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
      .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
   );

   typedef struct { int m; logic [31:0] dat; bit err; } exp_t;

   exp_t          sb[$];
   int            gnt_q[$];
   logic [AW-1:0] adr[NM];
   bit            cyc[NM];
   int            beats[NM], hold[NM], drop_in[NM];
   int            n_vec = 0, n_err = 0, stall_run = 0, wcnt = 0;
   logic [NM-1:0] prev_g = '0, smp_grant = '0, smp_ack = '0;
   logic          smp_cyc = 1'b0;
   bit            wd_next = 0;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_err(input logic [31:0] a);
      return a[31:16] == 16'hDEAD || a[31:28] == 4'hE;
   endfunction

   function automatic int idx_of(input logic [NM-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < NM; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic drive();
      for (int i = 0; i < NM; i++) begin
         m_cyc_i[i]           = cyc[i];
         m_stb_i[i]           = cyc[i];
         m_we_i[i]            = (i % 2) == 1;
         m_adr_i[i*AW +: AW]  = adr[i];
         m_dat_i[i*DW +: DW]  = ~adr[i];
         m_sel_i[i*SW +: SW]  = SW'(4'hF >> i);
      end
   endtask

   task automatic push(input int i);
      sb.push_back('{i, adr[i] ^ K, is_err(adr[i])});
   endtask

   task automatic start(input int i, input logic [31:0] a, input int n, input int h);
      adr[i] = a; beats[i] = n; hold[i] = h; drop_in[i] = -1; cyc[i] = 1;
      push(i);
      drive();
   endtask

   task automatic monitor();
      logic [NM-1:0] rsp;
      int o, f;
      rsp = m_ack_o | m_err_o;
      o = idx_of(grant_o);
      f = -1;
      if (wd_next) begin
         chk("abort_bus", {s_cyc_o, s_stb_o}, 2'b00);
         wd_next = 0;
      end
      if (grant_o == '0) chk("idle_bus", {s_cyc_o, s_stb_o}, 2'b00);
      else if (s_stb_o)
         chk("mux", {s_we_o, s_sel_o, s_dat_o, s_adr_o},
             {1'((o % 2) == 1), SW'(4'hF >> o), ~adr[o], adr[o]});
      stall_run = (s_stb_o && !s_ack_i && !s_err_i) ? stall_run + 1 : 0;
      if (rsp != '0) begin
         chk("rsp_owner", rsp, grant_o);
         for (int k = 0; k < sb.size(); k++) if (f < 0 && sb[k].m == idx_of(rsp)) f = k;
         chk("rsp_expected", f >= 0, 1'b1);
         if (f >= 0) begin
            chk("rsp_err", m_err_o != '0, sb[f].err);
            if (!sb[f].err) chk("rsp_dat", m_dat_o, sb[f].dat);
            sb.delete(f);
         end
         if (m_err_o != '0 && !s_err_i) begin
            chk("wdog_cycle", stall_run, TO + 1);
            wd_next = 1;
         end
      end
      if (grant_o != prev_g && grant_o != '0) begin
         chk("idle_gap", prev_g, '0);
         if (gnt_q.size() == 0) chk("grant_extra", grant_o, '0);
         else chk("grant", grant_o, NM'(1) << gnt_q.pop_front());
      end
      prev_g = grant_o;
   endtask

   task automatic step();
      logic [NM-1:0] ack_s, err_s;
      logic          stb_s, busy_s;
      logic [AW-1:0] adr_s;
      @(negedge clk);
      monitor();
      smp_cyc = s_cyc_o; smp_grant = grant_o; smp_ack = m_ack_o;
      ack_s = m_ack_o; err_s = m_err_o;
      stb_s = s_stb_o; busy_s = s_ack_i | s_err_i; adr_s = s_adr_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
         if (cyc[i]) begin
            if (drop_in[i] >= 0) begin
               if (drop_in[i] == 0) begin cyc[i] = 0; drop_in[i] = -1; end
               else drop_in[i]--;
            end else if (err_s[i]) begin
               if (hold[i] == 0) cyc[i] = 0;
               else drop_in[i] = hold[i] - 1;
            end else if (ack_s[i]) begin
               beats[i]--;
               if (beats[i] == 0) cyc[i] = 0;
               else begin adr[i] += 4; push(i); end
            end
         end
      end
      drive();
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_dat_i = $urandom;
      if (stb_s && !busy_s) begin
         if (adr_s[31:16] == 16'hDEAD) wcnt = 0;
         else if (wcnt == 1) begin
            wcnt = 0;
            s_ack_i = 1'b1;
            s_err_i = adr_s[31:28] == 4'hE;
            s_dat_i = adr_s ^ K;
         end else wcnt++;
      end else wcnt = 0;
   endtask

   task automatic run(input int max);
      int n;
      bit busy;
      n = 0;
      do begin
         step();
         n++;
         busy = sb.size() != 0 || gnt_q.size() != 0;
         for (int i = 0; i < NM; i++) busy |= cyc[i];
      end while (busy && n < max);
      chk("run_done", busy, 1'b0);
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL sim_limit: time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < NM; i++) begin
         adr[i] = '0; cyc[i] = 0; beats[i] = 0; hold[i] = 0; drop_in[i] = -1;
      end
      cyc[2] = 1;
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", grant_o, '0);
      chk("rst_scyc", s_cyc_o, 1'b0);
      chk("rst_sstb", s_stb_o, 1'b0);
      chk("rst_resp", m_ack_o | m_err_o, '0);
      cyc[2] = 0;
      drive();
      rst_n = 1'b1;

      start(0, 32'h9100_0000, 1, 0); gnt_q.push_back(0);
      step(); chk("lat_idle", smp_cyc, 1'b0);
      step(); chk("lat_own", smp_cyc, 1'b1);
      n = 0;
      while (!smp_ack[0] && n < 20) begin step(); n++; end
      chk("ack_vec", smp_ack, 4'b0001);
      step(); chk("cyc_drop", smp_cyc, 1'b0); chk("still_own", smp_grant, 4'b0001);
      step(); chk("released", smp_grant, 4'b0000);
      run(20);

      start(3, 32'h3000_0000, 1, 0); gnt_q.push_back(3); run(40);
      for (int i = 0; i < NM; i++) begin start(i, 32'h4000_0000 + 32'(i << 8), 1, 0); gnt_q.push_back(i); end
      run(100);
      start(1, 32'h1000_0100, 1, 0); gnt_q.push_back(1); run(40);
      for (int i = 0; i < NM; i++) start(i, 32'h5000_0000 + 32'(i << 8), 1, 0);
      for (int i = 0; i < NM; i++) gnt_q.push_back((i + 2) % NM);
      run(100);

      start(1, 32'h1000_0000, 8, 0); gnt_q.push_back(1);
      repeat (4) step();
      start(2, 32'h2200_0000, 1, 0); gnt_q.push_back(2);
      run(200);

      start(0, 32'hDEAD_0000, 1, 3); start(1, 32'h1200_0000, 1, 0);
      gnt_q.push_back(0); gnt_q.push_back(1);
      run(200);

      start(2, 32'hE000_0010, 1, 0); start(3, 32'h3300_0000, 2, 0);
      gnt_q.push_back(2); gnt_q.push_back(3);
      run(100);

      start(2, 32'h2000_0000, 1, 0); gnt_q.push_back(2); run(40);
      start(1, 32'h1100_0000, 8, 0); gnt_q.push_back(1);
      repeat (8) step();
      chk("pre_rst_own", smp_grant, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {s_cyc_o, s_stb_o, grant_o, m_ack_o, m_err_o}, '0);
      for (int i = 0; i < NM; i++) begin cyc[i] = 0; drop_in[i] = -1; end
      drive();
      sb.delete(); gnt_q.delete();
      s_ack_i = 1'b0; s_err_i = 1'b0; wcnt = 0; prev_g = '0; stall_run = 0; wd_next = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", grant_o, '0);
      rst_n = 1'b1;
      start(3, 32'h3400_0000, 1, 0); start(0, 32'h0400_0000, 1, 0);
      gnt_q.push_back(0); gnt_q.push_back(3);
      run(100);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
